// File: rtl/input_debouncer.sv
// Debounce front end for the edge detector: 2-flop synchronizer, counter-qualified
// level FSM with registered a_o/busy_o, and a saturating count of aborted transitions.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_i,
    input  logic                clr_glitch_i,
    output logic                a_o,
    output logic                busy_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // cnt + 1 == DEBOUNCE_CYCLES is evaluated as cnt == DEBOUNCE_CYCLES - 1
    localparam logic [CW-1:0]       CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  a_q, a_d;
    logic                  busy_q, busy_d;
    logic [GLITCH_W-1:0]   glitch_q, glitch_d;
    logic                  glitch_evt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        glitch_evt = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CW'(1);
                end
            end
            WAIT_HI: begin
                if (!sync2_q) begin
                    state_d    = STABLE_LO;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    a_d     = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!sync2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CW'(1);
                end
            end
            WAIT_LO: begin
                if (sync2_q) begin
                    state_d    = STABLE_HI;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    a_d     = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                a_d     = 1'b0;
            end
        endcase

        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);

        // Clear takes priority over a coincident glitch event
        glitch_d = glitch_q;
        if (clr_glitch_i) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            a_q      <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    assign a_o          = a_q;
    assign busy_o       = busy_q;
    assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (DEBOUNCE_CYCLES=4, GLITCH_W=2): each step queues
// the outputs expected after the next rising edge; a monitor pops and checks them.
module tb_input_debouncer;

    localparam int D  = 4;
    localparam int GW = 2;

    logic          clk;
    logic          reset;
    logic          raw_i;
    logic          clr_glitch_i;
    logic          a_o;
    logic          busy_o;
    logic [GW-1:0] glitch_cnt_o;

    typedef struct {
        string         tag;
        logic          a;
        logic          busy;
        logic [GW-1:0] g;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(D), .GLITCH_W(GW)) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_i        (raw_i),
        .clr_glitch_i (clr_glitch_i),
        .a_o          (a_o),
        .busy_o       (busy_o),
        .glitch_cnt_o (glitch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge; expectation applies after the following rising edge
    task automatic cyc(input logic r, input logic rst, input logic clr,
                       input logic ea, input logic eb, input int eg, input string tag);
        exp_t e;
        @(negedge clk);
        raw_i        = r;
        reset        = rst;
        clr_glitch_i = clr;
        e.tag  = tag;
        e.a    = ea;
        e.busy = eb;
        e.g    = GW'(eg);
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            assert (a_o === e.a) else begin
                bad++;
                $error("FAIL %s a_o got %b want %b", e.tag, a_o, e.a);
            end
            total++;
            assert (busy_o === e.busy) else begin
                bad++;
                $error("FAIL %s busy_o got %b want %b", e.tag, busy_o, e.busy);
            end
            total++;
            assert (glitch_cnt_o === e.g) else begin
                bad++;
                $error("FAIL %s glitch_cnt_o got %0d want %0d", e.tag, glitch_cnt_o, e.g);
            end
            $display("step %-10s a=%b busy=%b glitch=%0d", e.tag, a_o, busy_o, glitch_cnt_o);
        end
    end

    function automatic int min3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        reset        = 1'b1;
        raw_i        = 1'b0;
        clr_glitch_i = 1'b0;

        // Reset and idle
        for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "reset");
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "idle");

        // Clean rise then clean fall: busy after E2..E4, a_o flips at E5
        for (int k = 0; k < 10; k++)
            cyc(1'b1, 1'b0, 1'b0, k >= 5, (k >= 2 && k <= 4), 0, "rise");
        for (int k = 0; k < 10; k++)
            cyc(1'b0, 1'b0, 1'b0, k < 5, (k >= 2 && k <= 4), 0, "fall");

        // Bounce 1,1,0,0,1,1,0,0 then hold high: two aborts, a_o at final rise + 5
        for (int n = 0; n < 16; n++)
            cyc((n >= 8) || ((n % 4) < 2), 1'b0, 1'b0, n >= 13,
                (n < 8) ? ((n % 4) >= 2) : (n >= 10 && n <= 12),
                (n >= 8) ? 2 : ((n >= 4) ? 1 : 0), "bounce");
        for (int k = 0; k < 10; k++)
            cyc(1'b0, 1'b0, 1'b0, k < 5, (k >= 2 && k <= 4), 2, "bnc_fall");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "clear1");

        // Three-cycle pulse is rejected with one glitch
        for (int k = 0; k < 10; k++)
            cyc(k < 3, 1'b0, 1'b0, 1'b0, (k >= 2 && k <= 4), (k >= 5) ? 1 : 0, "pulse3");
        // Four-cycle pulse is accepted; WAIT_LO follows STABLE_HI with no dead time
        for (int k = 0; k < 12; k++)
            cyc(k < 4, 1'b0, 1'b0, (k >= 5 && k <= 8),
                (k >= 2 && k <= 4) || (k >= 6 && k <= 8), 1, "pulse4");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "clear2");

        // Five single-cycle glitches saturate the 2-bit counter at 3
        for (int i = 1; i <= 5; i++)
            for (int k = 0; k < 4; k++)
                cyc(k == 0, 1'b0, 1'b0, 1'b0, k == 2,
                    (k >= 3) ? min3(i) : min3(i - 1), "saturate");
        // Sixth glitch coincides with clear: clear wins
        for (int k = 0; k < 4; k++)
            cyc(k == 0, 1'b0, k == 3, 1'b0, k == 2, (k == 3) ? 0 : 3, "clr_vs_gl");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "after_clr");

        // Reset while WAIT_HI with cnt=2 and raw held high
        for (int n = 0; n < 4; n++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, n >= 2, 0, "pre_rst");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, "mid_rst");
        for (int n = 5; n < 13; n++)
            cyc(1'b1, 1'b0, 1'b0, n >= 10, (n >= 7 && n <= 9), 0, "post_rst");

        @(posedge clk);
        #3;
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain queue got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Front-end conditioning stage that sits directly upstream of the edge detector. It takes a raw, asynchronous, possibly bouncing input and passes it through a 2-flop synchronizer. It then applies a counter-based debounce FSM and drives a clean registered level, `a_o`, that connects straight to the edge detector's `a_i`. It also reports whether a debounce is in progress and keeps a saturating count of rejected glitches.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples at the new level required before `a_o` changes. Legal range 2..65535.
- `GLITCH_W`, default 8: width of the glitch counter.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `raw_i`  input  1  raw asynchronous input (button, external pin).
- `clr_glitch_i`  input  1  synchronous clear of `glitch_cnt_o`.
- `a_o`  output  1  debounced, registered level; feeds the edge detector's `a_i`.
- `busy_o`  output  1  high while a candidate transition is being qualified.
- `glitch_cnt_o`  output  GLITCH_W  number of aborted transitions, saturating.

## Operation
- Synchronizer: `sync1 <= raw_i`, `sync2 <= sync1`. Only `sync2` is used downstream. No logic touches `raw_i` directly.
- Sample counter `cnt` has width $clog2(DEBOUNCE_CYCLES+1).
- FSM has four states: `STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`.
- `STABLE_LO`:
  - `sync2`=1 → `WAIT_HI`, `cnt`=1.
  - Otherwise stay.
- `WAIT_HI`:
  - `sync2`=0 → `STABLE_LO`, `cnt`=0, glitch event.
  - `sync2`=1 and `cnt`+1 == DEBOUNCE_CYCLES → `STABLE_HI`, `a_o`<=1, `cnt`=0.
  - Otherwise `cnt`++.
- `STABLE_HI` and `WAIT_LO` behave symmetrically with levels inverted. Completion sets `a_o`<=0 and enters `STABLE_LO`.
- `a_o` changes only on a WAIT→STABLE transition. It never toggles in the same cycle as a glitch abort.
- `busy_o` is registered and equals 1 exactly while the state is `WAIT_HI` or `WAIT_LO`.
- Glitch counter:
  - A glitch event increments `glitch_cnt_o`.
  - At 2^GLITCH_W−1 the counter holds; no wrap.
  - `clr_glitch_i`=1 loads 0. A glitch event in the same cycle is discarded, so clear wins.
- Reset values: `sync1`=`sync2`=0, state `STABLE_LO`, `cnt`=0, `a_o`=0, `busy_o`=0, `glitch_cnt_o`=0.
- Reset mid-operation: any state, including WAIT with a partial count, returns to reset values on the next edge with `reset`=1. If `raw_i` stays high through release, qualification restarts from zero and no glitch is counted.

## Timing
- Latency: let E0 be the first edge that samples `raw_i` at its new level, held steady. Then:
  - `sync2` updates at E1.
  - The FSM takes its first qualifying sample at E2.
  - `a_o` changes at E(DEBOUNCE_CYCLES+1).
  - Total is DEBOUNCE_CYCLES+2 edges. For the default, `a_o` changes at the 6th edge.
- `busy_o` rises at E2 and falls on the same edge that `a_o` changes, or on the abort edge.
- Minimum accepted stable pulse is DEBOUNCE_CYCLES clocks as seen at `sync2`. A pulse of DEBOUNCE_CYCLES−1 clocks is rejected: exactly one glitch, `a_o` unchanged.
- A level that returns during WAIT aborts on the edge where `sync2` shows the old level. Qualification never resumes a partial count.
- Back-to-back transitions: after `STABLE_HI` is entered, a low at `sync2` on the very next edge enters `WAIT_LO` immediately. There is no dead time.
- Output is glitch-free and registered, so the edge detector sees at most one rising and one falling pulse per qualified transition.

## Test plan
- Reset/idle, DEBOUNCE_CYCLES=4, 10 ns clock: `reset`=1 for 2 cycles, `raw_i`=0 → `a_o`=0, `busy_o`=0, `glitch_cnt_o`=0 throughout.
- Clean rise: `raw_i` 0→1, held 10 cycles → `busy_o`=1 from edge E2 through E4; `a_o`=1 at E5 (6th edge counting E0); `glitch_cnt_o` stays 0. Release → `a_o`=0 at the same relative latency.
- Bounce: `raw_i` toggles 1,0,1,0 with 2-cycle periods, then holds 1 → `a_o` stays 0 during bounce; `glitch_cnt_o` increments per aborted qualification (2 for this pattern); `a_o`=1 DEBOUNCE_CYCLES+2 edges after the final rise.
- Short pulse: `raw_i` high for exactly 3 cycles → `a_o` never rises, `glitch_cnt_o`=1. A 4-cycle pulse → `a_o` high for 4 cycles.
- Saturation and clear, GLITCH_W=2:
  - Inject 5 glitches → `glitch_cnt_o` stops at 3.
  - Assert `clr_glitch_i` in the same cycle as a 6th glitch → `glitch_cnt_o`=0 next edge.
- Reset mid-qualification: assert `reset` while in `WAIT_HI` with `cnt`=2, `raw_i` held 1 → all outputs 0 after the reset edge; after release, `a_o` rises only after a full DEBOUNCE_CYCLES+2 edges; no glitch counted.
